mem_stage: RTL

- Memory-access pipeline stage. Sits directly downstream of the execute stage, upstream of write-back.
- Registers the execute-to-memory bus and completes loads against a variable-latency data SRAM read response.
- Sign/zero-extends sub-word load data and produces the memory-to-write-back bus.
- Exports forwarding signals and a stall request to the pipeline controller.

---
 rtl/mem_stage_pkg.sv | 45 ++++
 rtl/mem_stage_if.sv | 41 ++++
 rtl/mem_stage_load_ext.sv | 37 +++
 rtl/mem_stage.sv | 136 +++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Optional misaligned-load detection is enabled with MEM_ALIGN_CHECK_EN.
package mem_stage_pkg;

   localparam int DATA_W       = 32;
   localparam int EX_TO_MEM_WD = 79;
   localparam int MEM_TO_WB_WD = 70;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   typedef enum logic [2:0] {
      OP_LW  = 3'b000,
      OP_LB  = 3'b001,
      OP_LBU = 3'b010,
      OP_LH  = 3'b011,
      OP_LHU = 3'b100
   } mem_op_e;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_DONE  = 2'd2,
      S_DRAIN = 2'd3
   } mem_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [2:0]  mem_op;
      logic        ram_en;
      logic [3:0]  ram_wen;
      logic        sel_rf_res;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] result;
   } ex_mem_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] rf_wdata;
   } mem_wb_t;

endpackage

// File: rtl/mem_stage_if.sv
// Bus bundle between the pipeline, the data SRAM response and mem_stage.
// Carries mem_adel only when MEM_ALIGN_CHECK_EN is defined.
interface mem_stage_if;
   import mem_stage_pkg::*;

   logic [5:0]              stall;
   logic                    flush;
   logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
   logic [DATA_W-1:0]       data_sram_rdata;
   logic                    data_sram_data_ok;
   logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus;
   logic [DATA_W-1:0]       MEM_ID;
   logic                    MEM_wb_en;
   logic [4:0]              MEM_wb_r;
   logic                    MEM_sel_rf_res;
   logic                    stallreq_for_mem;
`ifdef MEM_ALIGN_CHECK_EN
   logic                    mem_adel;
`endif

   modport slave (
      input  stall, flush, ex_to_mem_bus,
      input  data_sram_rdata, data_sram_data_ok,
      output mem_to_wb_bus, MEM_ID, MEM_wb_en,
      output MEM_wb_r, MEM_sel_rf_res, stallreq_for_mem
`ifdef MEM_ALIGN_CHECK_EN
      , output mem_adel
`endif
   );

   modport master (
      output stall, flush, ex_to_mem_bus,
      output data_sram_rdata, data_sram_data_ok,
      input  mem_to_wb_bus, MEM_ID, MEM_wb_en,
      input  MEM_wb_r, MEM_sel_rf_res, stallreq_for_mem
`ifdef MEM_ALIGN_CHECK_EN
      , input mem_adel
`endif
   );

endinterface

// File: rtl/mem_stage_load_ext.sv
// Load lane selection and sign/zero extension (little-endian).
// Unlisted mem_op codes return the full word.
module load_ext
   import mem_stage_pkg::*;
(
   input  logic [2:0]  op_i,
   input  logic [1:0]  addr_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_w;
   logic [15:0] half_w;

   always_comb begin
      byte_w = rdata_i[7:0];
      unique case (addr_i)
         2'd1:    byte_w = rdata_i[15:8];
         2'd2:    byte_w = rdata_i[23:16];
         2'd3:    byte_w = rdata_i[31:24];
         default: byte_w = rdata_i[7:0];
      endcase
      half_w = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
   end

   always_comb begin
      data_o = rdata_i;
      unique case (1'b1)
         (op_i == OP_LB):  data_o = {{24{byte_w[7]}}, byte_w};
         (op_i == OP_LBU): data_o = {24'd0, byte_w};
         (op_i == OP_LH):  data_o = {{16{half_w[15]}}, half_w};
         (op_i == OP_LHU): data_o = {16'd0, half_w};
         default:          data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: registers the EX bus, completes loads against a
// variable-latency SRAM response. MEM_ALIGN_CHECK_EN adds misaligned-load kill.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic      clk,
   input  logic      resetn,
   mem_stage_if.slave bus_if
);

   ex_mem_t     bus_q, bus_d;
   mem_state_e  state_q;
   logic [31:0] buf_q;
   logic [31:0] ld_src;
   logic [31:0] ld_data;
   logic [31:0] wdata;
   logic        is_load;
   logic        stallreq;
   logic        we_eff;
   logic        data_ok;
   logic        stall_me;

   assign data_ok  = bus_if.data_sram_data_ok;
   assign stall_me = bus_if.stall[3];

   always_comb begin
      bus_d = bus_q;
      if (bus_if.flush)
         bus_d = '0;
      else if (stall_me == STOP && bus_if.stall[4] == NO_STOP)
         bus_d = '0;
      else if (stall_me == NO_STOP)
         bus_d = ex_mem_t'(bus_if.ex_to_mem_bus);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         bus_q <= '0;
      else
         bus_q <= bus_d;
   end

   assign is_load = bus_q.ram_en & (bus_q.ram_wen == 4'd0)
                  & bus_q.sel_rf_res;

   // A response captured while this stage is stalled lives in buf_q.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
         buf_q   <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (is_load) begin
                  if (data_ok) begin
                     if (stall_me && !bus_if.flush) begin
                        buf_q   <= bus_if.data_sram_rdata;
                        state_q <= S_DONE;
                     end
                  end else begin
                     state_q <= bus_if.flush ? S_DRAIN : S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (data_ok) begin
                  if (stall_me && !bus_if.flush) begin
                     buf_q   <= bus_if.data_sram_rdata;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_IDLE;
                  end
               end else if (bus_if.flush) begin
                  state_q <= S_DRAIN;
               end
            end
            S_DONE: begin
               if (!stall_me || bus_if.flush)
                  state_q <= S_IDLE;
            end
            S_DRAIN: begin
               if (data_ok)
                  state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      stallreq = 1'b0;
      ld_src   = bus_if.data_sram_rdata;
      unique case (state_q)
         S_IDLE:  stallreq = is_load & ~data_ok;
         S_WAIT:  stallreq = ~data_ok;
         S_DONE:  ld_src   = buf_q;
         S_DRAIN: stallreq = is_load;
         default: stallreq = 1'b0;
      endcase
   end

   load_ext u_load_ext (
      .op_i    (bus_q.mem_op),
      .addr_i  (bus_q.result[1:0]),
      .rdata_i (ld_src),
      .data_o  (ld_data)
   );

   assign wdata = is_load ? ld_data : bus_q.result;

`ifdef MEM_ALIGN_CHECK_EN
   logic op_half;
   logic op_sub;
   logic misalign;

   assign op_half  = (bus_q.mem_op == OP_LH) | (bus_q.mem_op == OP_LHU);
   assign op_sub   = op_half | (bus_q.mem_op == OP_LB)
                   | (bus_q.mem_op == OP_LBU);
   assign misalign = is_load
                   & ((op_half & bus_q.result[0])
                   |  (~op_sub & (bus_q.result[1:0] != 2'd0)));
   assign we_eff          = bus_q.rf_we & ~misalign;
   assign bus_if.mem_adel = misalign;
`else
   assign we_eff = bus_q.rf_we;
`endif

   assign bus_if.mem_to_wb_bus    = mem_wb_t'({bus_q.pc, we_eff,
                                               bus_q.rf_waddr, wdata});
   assign bus_if.MEM_ID           = wdata;
   assign bus_if.MEM_wb_en        = we_eff;
   assign bus_if.MEM_wb_r         = bus_q.rf_waddr;
   assign bus_if.MEM_sel_rf_res   = bus_q.sel_rf_res;
   assign bus_if.stallreq_for_mem = stallreq;

endmodule
